mux_arb_nto1: RTL and testbench

MUX_ARB_NTO1 -- requirements
Module: mux_arb_nto1

---
 rtl/mux_pkg.sv | 21 ++
 rtl/rr_arbiter_nto1.sv | 38 +++
 rtl/mux_arb_nto1.sv | 96 +++++++++
 tb/tb_mux_arb_nto1.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg : shared modes, FSM encodings and index-width helper  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   // Index width that never collapses to zero bits for small N.
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_nto1.sv
// ---------------------------------------------------------------------------
// rr_arbiter_nto1 : fixed-priority / round-robin one-hot grant  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_nto1 import mux_pkg::*; #(
   parameter int N  = 8,
   parameter int IW = clog2w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          mode,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic          found;
   logic [IW-1:0] cand;

   // Search starts at ptr in round-robin, at channel 0 in fixed priority.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = mode ? IW'((int'(ptr) + i) % N) : IW'(i);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux_arb_nto1.sv
// ---------------------------------------------------------------------------
// mux_arb_nto1 : N-to-1 arbitrated mux with a single registered output slot
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_arb_nto1 import mux_pkg::*; #(
   parameter int N    = 8,
   parameter int W    = 8,
   parameter int MODE = MODE_RR
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          in_valid,
   input  logic [N*W-1:0]        in_data,
   output logic [N-1:0]          in_ready,
   output logic                  out_valid,
   output logic [W-1:0]          out_data,
   input  logic                  out_ready,
   output logic [clog2w(N)-1:0]  grant_idx,
   output logic                  busy
);

   localparam int IW = clog2w(N);

   logic [0:0]    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  data_q, data_d;
   logic [N-1:0]  win_gnt;
   logic [IW-1:0] win_idx;
   logic [W-1:0]  ch_data [N];
   logic          slot_free;
   logic          accept;

   for (genvar k = 0; k < N; k++) begin : g_unpack
      assign ch_data[k] = in_data[k*W +: W];
   end

   rr_arbiter_nto1 #(
      .N  (N),
      .IW (IW)
   ) u_arb (
      .req  (in_valid),
      .ptr  (ptr_q),
      .mode (MODE == MODE_RR),
      .gnt  (win_gnt),
      .idx  (win_idx)
   );

   // rst_n gates acceptance so no grant escapes while reset is held.
   assign slot_free = (state_q == ST_EMPTY) || out_ready;
   assign accept    = rst_n && slot_free && (|in_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         ptr_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      data_d  = data_q;
      if (accept) begin
         state_d = ST_FULL;
         idx_d   = win_idx;
         data_d  = ch_data[win_idx];
         if (MODE == MODE_RR) begin
            ptr_d = (win_idx == IW'(N-1)) ? '0 : win_idx + 1'b1;
         end
      end else if ((state_q == ST_FULL) && out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_comb begin
      in_ready  = accept ? win_gnt : '0;
      out_valid = (state_q == ST_FULL);
      out_data  = data_q;
      grant_idx = idx_q;
      busy      = (|in_valid) || (state_q == ST_FULL);
   end

endmodule

`default_nettype wire

// File: tb/tb_mux_arb_nto1.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_nto1 : directed checks of round-robin and fixed-priority builds
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux_arb_nto1;

   logic        clk;
   logic        rst_n;

   logic [7:0]  rr_in_valid, rr_in_ready;
   logic [63:0] rr_in_data;
   logic        rr_out_valid, rr_out_ready, rr_busy;
   logic [7:0]  rr_out_data;
   logic [2:0]  rr_grant_idx;

   logic [7:0]  fp_in_valid, fp_in_ready;
   logic [63:0] fp_in_data;
   logic        fp_out_valid, fp_out_ready, fp_busy;
   logic [7:0]  fp_out_data;
   logic [2:0]  fp_grant_idx;

   int checks   = 0;
   int failures = 0;

   mux_arb_nto1 #(.N(8), .W(8), .MODE(1)) dut_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rr_in_valid),
      .in_data   (rr_in_data),
      .in_ready  (rr_in_ready),
      .out_valid (rr_out_valid),
      .out_data  (rr_out_data),
      .out_ready (rr_out_ready),
      .grant_idx (rr_grant_idx),
      .busy      (rr_busy)
   );

   mux_arb_nto1 #(.N(8), .W(8), .MODE(0)) dut_fp (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (fp_in_valid),
      .in_data   (fp_in_data),
      .in_ready  (fp_in_ready),
      .out_valid (fp_out_valid),
      .out_data  (fp_out_data),
      .out_ready (fp_out_ready),
      .grant_idx (fp_grant_idx),
      .busy      (fp_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ramp_data();
      for (int k = 0; k < 8; k++) begin
         rr_in_data[k*8 +: 8] = 8'(k);
         fp_in_data[k*8 +: 8] = 8'(k);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n        = 1'b0;
      rr_in_valid  = 8'hFF;
      fp_in_valid  = 8'h00;
      rr_out_ready = 1'b1;
      fp_out_ready = 1'b1;
      set_ramp_data();

      // Reset with every channel requesting
      tick();
      tick();
      chk("rst_out_valid", 64'(rr_out_valid), 64'h0);
      chk("rst_out_data",  64'(rr_out_data),  64'h0);
      chk("rst_grant_idx", 64'(rr_grant_idx), 64'h0);
      chk("rst_in_ready",  64'(rr_in_ready),  64'h0);
      chk("rst_busy",      64'(rr_busy),      64'h1);

      // Single channel 3 in round-robin
      rr_in_valid = 8'h00;
      rst_n       = 1'b1;
      tick();
      chk("idle_busy", 64'(rr_busy), 64'h0);
      rr_in_data[3*8 +: 8] = 8'hA5;
      rr_in_valid = 8'h08;
      #1;
      chk("single_in_ready", 64'(rr_in_ready), 64'h08);
      tick();
      rr_in_valid = 8'h00;
      chk("single_out_valid", 64'(rr_out_valid), 64'h1);
      chk("single_out_data",  64'(rr_out_data),  64'hA5);
      chk("single_grant_idx", 64'(rr_grant_idx), 64'h3);
      tick();
      chk("drain_out_valid", 64'(rr_out_valid), 64'h0);
      chk("drain_out_data",  64'(rr_out_data),  64'hA5);
      chk("drain_grant_idx", 64'(rr_grant_idx), 64'h3);

      // Round-robin wrap from pointer 0, one beat per cycle
      pulse_reset();
      set_ramp_data();
      rr_in_valid = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("rr_out_valid", 64'(rr_out_valid), 64'h1);
         chk("rr_grant_idx", 64'(rr_grant_idx), 64'(i % 8));
         chk("rr_out_data",  64'(rr_out_data),  64'(i % 8));
      end

      // Backpressure: load 8'h3C from channel 2 (pointer was 1)
      rr_in_valid = 8'h00;
      tick();
      chk("bp_empty", 64'(rr_out_valid), 64'h0);
      rr_in_data[2*8 +: 8] = 8'h3C;
      rr_in_valid = 8'h04;
      tick();
      chk("bp_load_data", 64'(rr_out_data), 64'h3C);
      rr_out_ready = 1'b0;
      rr_in_valid  = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_in_ready", 64'(rr_in_ready), 64'h00);
         tick();
         chk("bp_out_data",  64'(rr_out_data),  64'h3C);
         chk("bp_out_valid", 64'(rr_out_valid), 64'h1);
         chk("bp_grant_idx", 64'(rr_grant_idx), 64'h2);
      end
      rr_out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 64'(rr_in_ready), 64'h08);
      tick();
      chk("bp_release_out_valid", 64'(rr_out_valid), 64'h1);
      chk("bp_release_out_data",  64'(rr_out_data),  64'h03);
      chk("bp_release_grant_idx", 64'(rr_grant_idx), 64'h3);

      // Asynchronous reset while FULL
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(rr_out_valid), 64'h0);
      chk("arst_in_ready",  64'(rr_in_ready),  64'h00);
      chk("arst_out_data",  64'(rr_out_data),  64'h00);
      tick();
      chk("arst_hold_valid", 64'(rr_out_valid), 64'h0);
      rr_in_valid = 8'h20;
      rst_n       = 1'b1;
      tick();
      chk("arst_after_valid", 64'(rr_out_valid), 64'h1);
      chk("arst_after_grant", 64'(rr_grant_idx), 64'h5);
      rr_in_valid = 8'h00;

      // Fixed priority build
      fp_in_valid = 8'h81;
      #1;
      chk("fp_in_ready", 64'(fp_in_ready), 64'h01);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fp_grant_idx", 64'(fp_grant_idx), 64'h0);
         chk("fp_out_valid", 64'(fp_out_valid), 64'h1);
      end
      fp_in_valid = 8'h80;
      tick();
      chk("fp_grant_7",    64'(fp_grant_idx), 64'h7);
      chk("fp_out_data_7", 64'(fp_out_data),  64'h7);
      fp_in_valid = 8'h00;
      tick();
      chk("fp_drain_valid", 64'(fp_out_valid), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
